// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle RV32I datapath.
// Each instruction takes 3 to 5 clocks through the shared memory, IR, ALU and writeback paths.
// Also provides optional memory wait states, an illegal-opcode trap and a retired-instruction
// counter.
module multicycle_main_fsm #(
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 MemReq,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ImmSrc,
    output logic                 IllegalOp,
    output logic [CNT_WIDTH-1:0] InstrRetired
);

    localparam bit WaitEn = (MEM_WAIT != 0);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    // Mux select encodings
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAluRes = 2'b10;
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StIllegal  = 4'd11
    } state_e;

    state_e               state_q, state_d;
    state_e               state_dec;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mem_ready;
    logic                 retire;
    logic                 pc_update;
    logic                 branch;

    // With wait states disabled, every memory access completes in one cycle.
    assign mem_ready = !WaitEn || MemReady;

    // Next-state selection and retire detection.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecR, StExecI: begin
                state_d = StAluWb;
            end
            StAluWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StBeq: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StJal: begin
                state_d = StAluWb;
            end
            StIllegal: begin
                // Trapped until reset.
                state_d = StIllegal;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Retire counter next value; wraps naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrRetired = cnt_q;

    // During reset the mux selects show FETCH values so the datapath is parked predictably.
    assign state_dec = reset ? StFetch : state_q;

    // Moore output decode, with MemReady gating of the one-shot fetch enables.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        ALUOp     = AluAdd;
        IllegalOp = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        unique case (state_dec)
            StFetch: begin
                AdrSrc    = 1'b0;
                MemReq    = 1'b1;
                IRWrite   = mem_ready;
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ALUOp     = AluAdd;
                ResultSrc = ResAluRes;
                pc_update = mem_ready;
            end
            StDecode: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                ALUOp   = AluAdd;
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ALUOp   = AluAdd;
            end
            StMemRead: begin
                AdrSrc    = 1'b1;
                MemReq    = 1'b1;
                ResultSrc = ResAluOut;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                MemReq    = 1'b1;
                MemWrite  = 1'b1;
                ResultSrc = ResAluOut;
            end
            StExecR: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBRs2;
                ALUOp   = AluFunct;
            end
            StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ALUOp   = AluFunct;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = 1'b1;
            end
            StBeq: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBRs2;
                ALUOp     = AluSub;
                ResultSrc = ResAluOut;
                branch    = 1'b1;
            end
            StJal: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                ALUOp     = AluAdd;
                ResultSrc = ResAluOut;
                pc_update = 1'b1;
            end
            StIllegal: begin
                IllegalOp = 1'b1;
            end
            default: begin
                IllegalOp = 1'b0;
            end
        endcase

        // Branch resolves combinationally from Zero in the same cycle.
        PCWrite = pc_update | (branch & Zero);

        // Reset suppresses every write enable and the trap flag.
        if (reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            MemReq    = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    // Immediate format select, purely combinational from the opcode.
    always_comb begin
        case (op)
            OpLoad, OpIType: ImmSrc = 2'b00;
            OpStore:         ImmSrc = 2'b01;
            OpBeq:           ImmSrc = 2'b10;
            OpJal:           ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: one instance without wait states (32-bit counter) and one
// with wait states (3-bit counter), checked cycle by cycle against an instruction-level model.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MEM_WAIT=0, CNT_WIDTH=32
    logic        a_rst, a_zero, a_rdy;
    logic [6:0]  a_op;
    logic        a_pcw, a_adr, a_mw, a_mreq, a_irw, a_rw, a_ill;
    logic [1:0]  a_rs, a_sa, a_sb, a_aop, a_imm;
    logic [31:0] a_cnt;

    // Instance B: MEM_WAIT=1, CNT_WIDTH=3
    logic        b_rst, b_zero, b_rdy;
    logic [6:0]  b_op;
    logic        b_pcw, b_adr, b_mw, b_mreq, b_irw, b_rw, b_ill;
    logic [1:0]  b_rs, b_sa, b_sb, b_aop, b_imm;
    logic [2:0]  b_cnt;

    multicycle_main_fsm #(.MEM_WAIT(0), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .reset(a_rst), .op(a_op), .Zero(a_zero), .MemReady(a_rdy),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .MemReq(a_mreq), .IRWrite(a_irw),
        .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop),
        .ImmSrc(a_imm), .IllegalOp(a_ill), .InstrRetired(a_cnt)
    );

    multicycle_main_fsm #(.MEM_WAIT(1), .CNT_WIDTH(3)) u_dut_b (
        .clk(clk), .reset(b_rst), .op(b_op), .Zero(b_zero), .MemReady(b_rdy),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .MemReq(b_mreq), .IRWrite(b_irw),
        .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop),
        .ImmSrc(b_imm), .IllegalOp(b_ill), .InstrRetired(b_cnt)
    );

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    // Instruction kinds
    localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KBeq = 4, KJal = 5, KIll = 6;
    // Step roles within an instruction
    localparam int RFetch = 0, RDec = 1, RMemAdr = 2, RMemRd = 3, RMemWb = 4, RMemWr = 5;
    localparam int RExecR = 6, RExecI = 7, RAluWb = 8, RBeq = 9, RJal = 10, RIll = 11;

    int checks = 0;
    int failures = 0;

    // Model state per instance: kind of current instruction, cycle index within it, retire count.
    int          m_kind[2];
    int          m_phase[2];
    int unsigned m_cnt[2];

    logic       rst_v, zero_v, rdy_v;
    logic [6:0] op_v;

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            LW:      return KLw;
            SW:      return KSw;
            RT:      return KR;
            IT:      return KI;
            BEQ:     return KBeq;
            JAL:     return KJal;
            default: return KIll;
        endcase
    endfunction

    // Cycles per instruction with no waiting; illegal never completes.
    function automatic int len_of(input int k);
        case (k)
            KLw:     return 5;
            KBeq:    return 3;
            KIll:    return 1000000;
            default: return 4;
        endcase
    endfunction

    function automatic int role_of(input int k, input int ph);
        if (ph == 0) return RFetch;
        if (ph == 1) return RDec;
        case (k)
            KLw:     return (ph == 2) ? RMemAdr : (ph == 3) ? RMemRd : RMemWb;
            KSw:     return (ph == 2) ? RMemAdr : RMemWr;
            KR:      return (ph == 2) ? RExecR : RAluWb;
            KI:      return (ph == 2) ? RExecI : RAluWb;
            KBeq:    return RBeq;
            KJal:    return (ph == 2) ? RJal : RAluWb;
            default: return RIll;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            LW, IT:  return 2'b00;
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Packed as {PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite, ResultSrc, ALUSrcA,
    // ALUSrcB, ALUOp, IllegalOp}.
    function automatic logic [14:0] exp_out(input int role, input logic z, input logic rdy,
                                            input bit wait_en, input logic rst);
        logic       pcu, br, pcw, adr, mw, mreq, irw, rw, ill;
        logic [1:0] rs, sa, sb, aop;
        {pcu, br, adr, mw, mreq, irw, rw, ill} = '0;
        {rs, sa, sb, aop} = '0;
        case (role)
            RFetch: begin
                mreq = 1; irw = 1; sb = 2; rs = 2; pcu = 1;
                if (wait_en && !rdy) begin irw = 0; pcu = 0; end
            end
            RDec:    begin sa = 1; sb = 1; end
            RMemAdr: begin sa = 2; sb = 1; end
            RMemRd:  begin adr = 1; mreq = 1; end
            RMemWb:  begin rs = 1; rw = 1; end
            RMemWr:  begin adr = 1; mreq = 1; mw = 1; end
            RExecR:  begin sa = 2; aop = 2; end
            RExecI:  begin sa = 2; sb = 1; aop = 2; end
            RAluWb:  begin rw = 1; end
            RBeq:    begin sa = 2; aop = 1; br = 1; end
            RJal:    begin sa = 1; sb = 2; pcu = 1; end
            default: begin ill = 1; end
        endcase
        pcw = pcu | (br & z);
        if (rst) begin
            {pcw, adr, mw, mreq, irw, rw, ill} = '0;
            rs = 2; sa = 0; sb = 2; aop = 0;
        end
        return {pcw, adr, mw, mreq, irw, rw, rs, sa, sb, aop, ill};
    endfunction

    task automatic check(input int id);
        logic [14:0] obs, exp;
        logic [1:0]  imm_obs;
        logic [31:0] cnt_obs, cnt_exp;
        if (id == 0) begin
            obs = {a_pcw, a_adr, a_mw, a_mreq, a_irw, a_rw, a_rs, a_sa, a_sb, a_aop, a_ill};
            imm_obs = a_imm;
            cnt_obs = a_cnt;
            cnt_exp = m_cnt[0];
        end else begin
            obs = {b_pcw, b_adr, b_mw, b_mreq, b_irw, b_rw, b_rs, b_sa, b_sb, b_aop, b_ill};
            imm_obs = b_imm;
            cnt_obs = {29'd0, b_cnt};
            cnt_exp = m_cnt[1] & 32'd7;
        end
        exp = exp_out(role_of(m_kind[id], m_phase[id]), zero_v, rdy_v, id == 1, rst_v);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL ctl dut%0d t=%0t observed=%b expected=%b", id, $time, obs, exp);
        end
        checks++;
        assert (imm_obs === imm_of(op_v)) else begin
            failures++;
            $error("FAIL immsrc dut%0d t=%0t observed=%b expected=%b", id, $time, imm_obs,
                   imm_of(op_v));
        end
        checks++;
        assert (cnt_obs === cnt_exp) else begin
            failures++;
            $error("FAIL retired dut%0d t=%0t observed=%0d expected=%0d", id, $time, cnt_obs,
                   cnt_exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge(input int id);
        int role;
        bit stalled;
        if (rst_v) begin
            m_phase[id] = 0;
            m_cnt[id]   = 0;
        end else begin
            role = role_of(m_kind[id], m_phase[id]);
            stalled = (id == 1) && !rdy_v && (role == RFetch || role == RMemRd || role == RMemWr);
            if (!stalled && role != RIll) begin
                if (m_phase[id] == 1) m_kind[id] = kind_of(op_v);
                if (m_phase[id] + 1 == len_of(m_kind[id])) begin
                    m_phase[id] = 0;
                    m_cnt[id]++;
                end else begin
                    m_phase[id]++;
                end
            end
        end
    endtask

    task automatic tick(input int id);
        if (id == 0) begin
            a_rst = rst_v; a_op = op_v; a_zero = zero_v; a_rdy = rdy_v;
        end else begin
            b_rst = rst_v; b_op = op_v; b_zero = zero_v; b_rdy = rdy_v;
        end
        #1;
        check(id);
        @(posedge clk);
        model_edge(id);
        #1;
    endtask

    // Run one whole instruction; bounded so a stuck model or DUT cannot hang the bench.
    task automatic run_instr(input int id, input logic [6:0] o, input logic z);
        int n = 0;
        op_v = o; zero_v = z; rst_v = 1'b0;
        do begin
            tick(id);
            n++;
        end while (m_phase[id] != 0 && n < 40);
        checks++;
        assert (n < 40) else begin
            failures++;
            $error("FAIL instr_bound dut%0d observed=%0d cycles expected<40", id, n);
        end
    endtask

    function automatic logic [6:0] pick_op();
        int r = $urandom_range(0, 15);
        if (r < 3)  return LW;
        if (r < 5)  return SW;
        if (r < 8)  return RT;
        if (r < 10) return IT;
        if (r < 12) return BEQ;
        if (r < 14) return JAL;
        if (r == 14) return 7'($urandom);
        return 7'h7f;
    endfunction

    task automatic run_random(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            if (m_phase[id] == 0) op_v = pick_op();
            zero_v = 1'($urandom_range(0, 1));
            rdy_v  = (id == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            rst_v  = ($urandom_range(0, 39) == 0);
            tick(id);
        end
        rst_v = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_op = '0; a_zero = 1'b0; a_rdy = 1'b0;
        b_rst = 1'b1; b_op = '0; b_zero = 1'b0; b_rdy = 1'b0;
        rst_v = 1'b1; op_v = '0; zero_v = 1'b0; rdy_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_kind[i] = KLw; m_phase[i] = 0; m_cnt[i] = 0;
        end
        // Bring both instances out of power-up X before any check.
        @(posedge clk);
        @(posedge clk);
        #1;

        // Instance A: directed sequence
        rst_v = 1'b1; tick(0); tick(0);
        run_instr(0, LW, 1'b0);
        run_instr(0, BEQ, 1'b1);
        run_instr(0, BEQ, 1'b0);
        run_instr(0, JAL, 1'b0);
        run_instr(0, SW, 1'b0);
        run_instr(0, IT, 1'b1);
        run_instr(0, RT, 1'b0);
        op_v = 7'h7f;
        for (int i = 0; i < 14; i++) tick(0);
        rst_v = 1'b1; tick(0);
        run_instr(0, RT, 1'b0);
        run_random(0, 400);

        // Instance B: park A in reset, then wait-state and counter-wrap scenarios
        a_rst = 1'b1;
        rst_v = 1'b1; rdy_v = 1'b1; tick(1); tick(1);
        rst_v = 1'b0; op_v = SW;
        tick(1); tick(1); tick(1);
        rdy_v = 1'b0;
        for (int i = 0; i < 3; i++) tick(1);
        rdy_v = 1'b1; tick(1);
        rdy_v = 1'b0; tick(1); tick(1);
        rdy_v = 1'b1;
        run_instr(1, LW, 1'b0);
        for (int i = 0; i < 9; i++) run_instr(1, RT, 1'b0);
        op_v = RT; tick(1); tick(1);
        rst_v = 1'b1; tick(1);
        rst_v = 1'b0;
        run_instr(1, BEQ, 1'b1);
        run_random(1, 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
